// File: rtl/alu_iter_exec_if.sv
// Request/response bundle between the operand stage and the iterative ALU.
// Handshake: a request is taken on a rising edge where alu_start=1 and alu_busy=0;
// a start seen while alu_busy=1 is dropped. alu_done pulses for one cycle per taken request.
interface alu_iter_exec_if #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 3
);
  logic                  alu_start;
  logic [OP_WIDTH-1:0]   alu_op;
  logic [DATA_WIDTH-1:0] alu_a_in;
  logic [DATA_WIDTH-1:0] alu_b_in;
  logic                  alu_busy;
  logic                  alu_done;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_overflow;
  logic                  alu_dbg_state;

  modport master (
    output alu_start, alu_op, alu_a_in, alu_b_in,
    input  alu_busy, alu_done, alu_result, alu_overflow, alu_dbg_state
  );

  modport slave (
    input  alu_start, alu_op, alu_a_in, alu_b_in,
    output alu_busy, alu_done, alu_result, alu_overflow, alu_dbg_state
  );
endinterface

// File: rtl/alu_iter_exec.sv
// Execute-stage ALU: single-cycle ADD/SUB/SLT/SLL/SRL and a DATA_WIDTH-iteration
// shift-add MUL. The current FSM state is exposed on bus.alu_dbg_state (0=IDLE, 1=MUL).
module alu_iter_exec #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 3
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  alu_iter_exec_if.slave  bus
);
  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam int SHW   = $clog2(DATA_WIDTH);
  localparam int MSB   = DATA_WIDTH - 1;

  localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OP_SUB = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_SLT = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OP_SLL = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] OP_SRL = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] OP_MUL = OP_WIDTH'(5);
  localparam logic [CNT_W-1:0]    LAST_ITER = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_e;

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0] mcand_q;
  logic [DATA_WIDTH-1:0] mplier_q;
  logic [DATA_WIDTH-1:0] acc_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  overflow_q;
  logic                  done_q;
  logic                  busy_q;

  logic [DATA_WIDTH-1:0] a, b, sum, diff;
  logic [DATA_WIDTH-1:0] result_d;
  logic                  overflow_d;
  logic [DATA_WIDTH-1:0] acc_d;

  assign a    = bus.alu_a_in;
  assign b    = bus.alu_b_in;
  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    result_d   = '0;
    overflow_d = 1'b0;
    case (bus.alu_op)
      OP_ADD: begin
        result_d   = sum;
        overflow_d = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        result_d   = diff;
        overflow_d = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      OP_SLT:  result_d = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL:  result_d = a << b[SHW-1:0];
      OP_SRL:  result_d = a >> b[SHW-1:0];
      default: result_d = '0;
    endcase
  end

  // One shift-add step; the final step's sum is the product's low word.
  assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.alu_start) begin
            if (bus.alu_op == OP_MUL) begin
              mcand_q  <= a;
              mplier_q <= b;
              acc_q    <= '0;
              cnt_q    <= '0;
              busy_q   <= 1'b1;
              state_q  <= S_MUL;
            end else begin
              result_q   <= result_d;
              overflow_q <= overflow_d;
              done_q     <= 1'b1;
            end
          end
        end
        S_MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          if (cnt_q == LAST_ITER) begin
            result_q   <= acc_d;
            overflow_q <= 1'b0;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            cnt_q      <= '0;
            state_q    <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.alu_busy      = busy_q;
  assign bus.alu_done      = done_q;
  assign bus.alu_result    = result_q;
  assign bus.alu_overflow  = overflow_q;
  assign bus.alu_dbg_state = state_q;
endmodule

// File: tb/tb_alu_iter_exec.sv
// Self-checking bench for alu_iter_exec: expected {overflow,result} words are queued
// when a request is driven and compared when alu_done pulses.
module tb_alu_iter_exec;
  localparam int DW = 32;
  localparam int OW = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_iter_exec_if #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) bus ();

  alu_iter_exec #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  logic [DW:0] exp_q[$];
  logic [DW:0] last_exp = '0;
  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int push_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model: {overflow, result}, overflow from a widened signed sum.
  function automatic logic [DW:0] model(input logic [OW-1:0] op, input logic [DW-1:0] a,
                                        input logic [DW-1:0] b);
    logic signed [DW:0] s;
    logic [63:0]        p;
    logic [DW-1:0]      r;
    logic               ov;
    r  = '0;
    ov = 1'b0;
    case (op)
      3'd0: begin s = $signed({a[DW-1], a}) + $signed({b[DW-1], b}); r = s[DW-1:0]; ov = s[DW] ^ s[DW-1]; end
      3'd1: begin s = $signed({a[DW-1], a}) - $signed({b[DW-1], b}); r = s[DW-1:0]; ov = s[DW] ^ s[DW-1]; end
      3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: r = a << b[4:0];
      3'd4: r = a >> b[4:0];
      3'd5: begin p = {32'd0, a} * {32'd0, b}; r = p[DW-1:0]; end
      default: r = '0;
    endcase
    return {ov, r};
  endfunction

  // Scoreboard: every done must match the oldest outstanding request.
  always @(negedge clk) begin : monitor
    logic [DW:0] e;
    if (rst_n && bus.alu_done) begin
      done_cnt++;
      check("done_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        last_exp = e;
        check("result", 64'(bus.alu_result), 64'(e[DW-1:0]));
        check("overflow", 64'(bus.alu_overflow), 64'(e[DW]));
      end
    end
  end

  // Called on a falling edge; holds start for exactly one rising edge.
  task automatic drive(input logic [OW-1:0] op, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input bit push);
    bus.alu_start = 1'b1;
    bus.alu_op    = op;
    bus.alu_a_in  = a;
    bus.alu_b_in  = b;
    if (push) begin
      exp_q.push_back(model(op, a, b));
      push_cnt++;
    end
    @(negedge clk);
    bus.alu_start = 1'b0;
  endtask

  // Called right after drive() of a MUL; optionally hammers the inputs while busy.
  task automatic wait_mul(input bit noise);
    int n;
    n = 0;
    while (bus.alu_busy && n < 100) begin
      if (noise) begin
        bus.alu_start = (n % 4 == 1);
        bus.alu_op    = OW'($urandom_range(0, 7));
        bus.alu_a_in  = $urandom;
        bus.alu_b_in  = $urandom;
      end
      n++;
      @(negedge clk);
    end
    bus.alu_start = 1'b0;
    check("mul_busy_cycles", 64'(n), 64'd32);
    check("mul_done_at_busy_fall", 64'(bus.alu_done), 64'd1);
  endtask

  initial begin
    int d0;
    logic [OW-1:0] op;
    logic [DW-1:0] ra, rb;
    bus.alu_start = 1'b0;
    bus.alu_op    = '0;
    bus.alu_a_in  = '0;
    bus.alu_b_in  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus.alu_busy), 64'd0);
    check("rst_done", 64'(bus.alu_done), 64'd0);
    check("rst_result", 64'(bus.alu_result), 64'd0);
    check("rst_overflow", 64'(bus.alu_overflow), 64'd0);
    check("rst_state", 64'(bus.alu_dbg_state), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed single-cycle ops, back to back.
    drive(3'd0, 32'h7FFF_FFFF, 32'd1, 1'b1);
    drive(3'd1, 32'd0, 32'd1, 1'b1);
    drive(3'd2, 32'hFFFF_FFFF, 32'd1, 1'b1);
    drive(3'd3, 32'd1, 32'h0000_0024, 1'b1);
    drive(3'd4, 32'h8000_0000, 32'd31, 1'b1);
    drive(3'd6, 32'h1234_5678, 32'h9abc_def0, 1'b1);
    drive(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    repeat (4) @(negedge clk);
    check("result_hold", 64'(bus.alu_result), 64'(last_exp[DW-1:0]));
    check("done_low_idle", 64'(bus.alu_done), 64'd0);

    // MUL then ADD started in the done cycle.
    drive(3'd5, 32'd1234, 32'd5678, 1'b1);
    wait_mul(1'b0);
    drive(3'd0, 32'd2, 32'd3, 1'b1);
    @(negedge clk);

    // MUL with ignored starts and toggling operands.
    drive(3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_mul(1'b1);
    repeat (3) @(negedge clk);
    check("noise_queue_empty", 64'(exp_q.size()), 64'd0);
    check("noise_done_count", 64'(done_cnt), 64'(push_cnt));

    // Random single-cycle ops, back to back.
    for (int i = 0; i < 24; i++) begin
      op = OW'($urandom_range(0, 6));
      if (op == 3'd5) op = 3'd7;
      ra = (i % 5 == 0) ? 32'h8000_0000 : $urandom;
      rb = (i % 7 == 0) ? 32'h7FFF_FFFF : $urandom;
      drive(op, ra, rb, 1'b1);
    end
    @(negedge clk);

    // Random MULs.
    for (int i = 0; i < 3; i++) begin
      drive(3'd5, $urandom, $urandom, 1'b1);
      wait_mul(1'b0);
    end
    repeat (2) @(negedge clk);

    // Asynchronous reset at iteration 10 of a MUL aborts it.
    drive(3'd5, 32'd1234, 32'd5678, 1'b0);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(bus.alu_busy), 64'd0);
    check("abort_done", 64'(bus.alu_done), 64'd0);
    check("abort_result", 64'(bus.alu_result), 64'd0);
    check("abort_overflow", 64'(bus.alu_overflow), 64'd0);
    check("abort_state", 64'(bus.alu_dbg_state), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    d0 = done_cnt;
    repeat (40) @(negedge clk);
    check("no_done_after_abort", 64'(done_cnt), 64'(d0));
    check("idle_after_abort", 64'(bus.alu_busy), 64'd0);

    drive(3'd0, 32'd5, 32'd6, 1'b1);
    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("done_count", 64'(done_cnt), 64'(push_cnt));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
